// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the iteration counter width.
package div_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem, quo} left,
// try to subtract the divisor, and keep the difference if it did not borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_quo
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < dvs <= 2^(WIDTH-1), so the shifted value never overflows WIDTH+1
   // bits and the top bit of trial is a clean borrow flag.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, dvs};
      next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
   end

endmodule

// File: rtl/divisor.sv
// Sequential signed divider (MIPS div semantics): remainder on hi, quotient
// on lo, WIDTH restoring steps followed by a sign-fix cycle.
module divisor
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic [WIDTH-1:0] quo_reg, quo_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             sign_q_reg, sign_q_next;
   logic             sign_r_reg, sign_r_next;
   logic             div_zero_reg, div_zero_next;

   logic [WIDTH-1:0] step_rem, step_quo;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Magnitude of the most negative value wraps to itself, which is the
   // correct unsigned magnitude, so no special case is needed.
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .dvs      (dvs_reg),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rem_next      = rem_reg;
      quo_next      = quo_reg;
      dvs_next      = dvs_reg;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      sign_q_next   = sign_q_reg;
      sign_r_next   = sign_r_reg;
      div_zero_next = div_zero_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (state_reg == DONE)
               state_next = IDLE;
            if (div_control) begin
               if (b == '0) begin
                  div_zero_next = 1'b1;
                  state_next    = DONE;
               end else begin
                  div_zero_next = 1'b0;
                  rem_next      = '0;
                  quo_next      = a_mag;
                  dvs_next      = b_mag;
                  sign_q_next   = a[WIDTH-1] ^ b[WIDTH-1];
                  sign_r_next   = a[WIDTH-1];
                  cnt_next      = CW'(WIDTH - 1);
                  state_next    = CALC;
               end
            end
         end
         CALC: begin
            rem_next = step_rem;
            quo_next = step_quo;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == '0)
               state_next = FIX;
         end
         FIX: begin
            lo_next       = sign_q_reg ? -quo_reg : quo_reg;
            hi_next       = sign_r_reg ? -rem_reg : rem_reg;
            div_zero_next = 1'b0;
            state_next    = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         dvs_reg      <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         sign_q_reg   <= 1'b0;
         sign_r_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rem_reg      <= rem_next;
         quo_reg      <= quo_next;
         dvs_reg      <= dvs_next;
         hi_reg       <= hi_next;
         lo_reg       <= lo_next;
         sign_q_reg   <= sign_q_next;
         sign_r_reg   <= sign_r_next;
         div_zero_reg <= div_zero_next;
      end
   end

   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign busy     = (state_reg == CALC) || (state_reg == FIX);
   assign done     = (state_reg == DONE);
   assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: directed cases, randomized operands,
// ignored mid-run starts, asynchronous reset and back-to-back starts.
module tb_divisor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        div_control = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   divisor #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .div_control (div_control),
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit signed arithmetic truncates toward zero and gives the
   // remainder the dividend's sign, exactly the MIPS div result.
   task automatic model_div(input logic [31:0] av, input logic [31:0] bv);
      longint la, lb, q, r;
      if (bv != 32'd0) begin
         la = longint'($signed(av));
         lb = longint'($signed(bv));
         q  = la / lb;
         r  = la % lb;
         exp_lo = q[31:0];
         exp_hi = r[31:0];
      end
   endtask

   task automatic launch(input logic [31:0] av, input logic [31:0] bv, input bit at_negedge);
      if (at_negedge) @(negedge clk);
      a = av;
      b = bv;
      div_control = 1'b1;
      @(posedge clk);
      #1;
      div_control = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Called at E0+1; counts edges until done is seen. poke >= 1 injects an
   // extra start at edge E(poke), which must be ignored.
   task automatic wait_done(input int poke, output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (!done && lat < 100) begin
         if (busy) bc++;
         if (lat == poke - 1) begin
            div_control = 1'b1;
            a = 32'd1;
            b = 32'd1;
         end
         @(posedge clk);
         #1;
         div_control = 1'b0;
         lat++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic verify(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input int bc);
      model_div(av, bv);
      check({tag, "_lat"},  lat, (bv == 0) ? 32'd0 : 32'd33);
      check({tag, "_busy"}, bc,  (bv == 0) ? 32'd0 : 32'd33);
      check({tag, "_lo"},   lo,  exp_lo);
      check({tag, "_hi"},   hi,  exp_hi);
      check({tag, "_dz"},   {31'd0, div_zero}, {31'd0, bv == 0});
      $display("div a=%h b=%h -> lo=%h hi=%h dz=%0d lat=%0d", av, bv, lo, hi, div_zero, lat);
   endtask

   task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv);
      int lat, bc;
      launch(av, bv, 1'b1);
      wait_done(-1, lat, bc);
      verify(tag, av, bv, lat, bc);
   endtask

   logic [31:0] dir_a [6] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd0, 32'd7};
   logic [31:0] dir_b [6] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5, 32'd2};

   initial begin
      int lat, bc;
      logic [31:0] av, bv;
      int sel;

      repeat (3) @(posedge clk);
      #1;
      check("rst_hi",   hi, 32'd0);
      check("rst_lo",   lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dz",   {31'd0, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++)
         run("dir", dir_a[i], dir_b[i]);
      // Divide by zero right after 7/2: hi/lo keep 1/3.
      run("dz", 32'd9, 32'd0);
      check("dz_lo_keep", lo, 32'd3);
      check("dz_hi_keep", hi, 32'd1);

      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 9);
         av  = (sel[0]) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
         if (sel == 0)      bv = 32'd0;
         else if (sel < 5)  bv = $urandom;
         else               bv = 32'($signed($urandom_range(1, 60)) * ((sel > 7) ? -1 : 1));
         run("rnd", av, bv);
      end

      // Start pulse during CALC is ignored.
      launch(32'd100, 32'd7, 1'b1);
      wait_done(10, lat, bc);
      verify("ign", 32'd100, 32'd7, lat, bc);
      check("ign_lo_abs", lo, 32'd14);

      // Asynchronous reset mid-division.
      launch(32'd100, 32'd7, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("arst_hi",   hi, 32'd0);
      check("arst_lo",   lo, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_dz",   {31'd0, div_zero}, 32'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      run("post_rst", 32'd100, 32'd7);
      check("post_rst_lo", lo, 32'd14);
      check("post_rst_hi", hi, 32'd2);

      // Back-to-back: new start issued during the done cycle.
      run("b2b_first", 32'd20, 32'd3);
      launch(32'hFFFFFFEC, 32'd3, 1'b0);
      wait_done(-1, lat, bc);
      verify("b2b_second", 32'hFFFFFFEC, 32'd3, lat, bc);
      check("b2b_lo", lo, 32'hFFFFFFFA);
      check("b2b_hi", hi, 32'hFFFFFFFE);

      @(posedge clk);
      #1;
      check("idle_after_done", {31'd0, done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
